usb_serial_fifo_bridge: RTL and testbench
=========================================

// Module: usb_serial_fifo_bridge
// PURPOSE
//  - Byte-buffering stage between usb_device_controller's serial application interface and the Wishbone serial register block.
//  - RX path: one FIFO from USB to CPU. TX path: one FIFO from CPU to USB.
//  - Absorbs USB bulk-packet bursts so the CPU side no longer works one byte at a time.
//  - Sits in the clk_48mhz domain; both sides use valid/ready handshakes.
// PARAMETERS
//  - DATA_W      8   byte width of each FIFO entry
//  - DEPTH_LOG2  6   log2 of FIFO depth (64 entries per direction); legal range 2..10
// PORTS
//  - clk           in   1        single clock; every register in the block uses this clock
//  - rst_n         in   1        asynchronous active-low reset; assertion is asynchronous, deassertion is synchronous to clk
//  - usb_rx_data   in   DATA_W   byte from the USB controller
//  - usb_rx_valid  in   1        usb_rx_data is valid
//  - usb_rx_ready  out  1        RX FIFO can accept a byte
//  - rx_data       out  DATA_W   head of the RX FIFO, presented to the CPU side
//  - rx_valid      out  1        RX FIFO is not empty
//  - rx_ready      in   1        CPU side pops the RX head
//  - tx_data       in   DATA_W   byte from the CPU side
//  - tx_valid      in   1        tx_data is valid
//  - tx_ready      out  1        TX FIFO can accept a byte
//  - usb_tx_data   out  DATA_W   head of the TX FIFO, presented to the USB controller
//  - usb_tx_valid  out  1        TX FIFO is not empty
//  - usb_tx_ready  in   1        USB controller consumes the TX head
//  - rx_level      out  DEPTH_LOG2+1  number of bytes in the RX FIFO
//  - tx_level      out  DEPTH_LOG2+1  number of bytes in the TX FIFO
//  - flush_rx      in   1        (USB_FIFO_FLUSH_EN only) empties the RX FIFO
//  - flush_tx      in   1        (USB_FIFO_FLUSH_EN only) empties the TX FIFO
// BEHAVIOUR
//  - Handshake: a transfer happens on a rising clk edge where valid && ready. valid must not depend on ready.
//  - Reset values: all FIFOs empty, pointers 0, levels 0, *_ready=1, *_valid=0, data outputs 0.
//  - Reset asserted mid-operation discards all buffered bytes and takes effect immediately.
//  - Full/empty flags are registered:
//    - write-ready = !full and is derived from the registered count only.
//    - A pop in the same cycle does NOT re-open ready while the FIFO is full.
//  - FIFO output is first-word fall-through with a registered head:
//    - A byte pushed into an empty FIFO appears with valid=1 on the next cycle (1-cycle latency).
//    - After a pop, the next head appears on the following cycle with no bubble.
//    - Sustained throughput is 1 byte/clk in each direction.
//  - Data outputs hold their value while valid=1 && ready=0.
//    - They are don't-care when valid=0, but are driven to 0 after reset.
//  - Pointers are DEPTH_LOG2 bits and wrap modulo 2^DEPTH_LOG2.
//  - count is DEPTH_LOG2+1 bits, ranging 0..2^DEPTH_LOG2:
//    - full = (count == 2^DEPTH_LOG2); empty = (count == 0).
//  - Count update per clk edge:
//    - push only: count+1
//    - pop only: count-1
//    - push and pop together (possible only when not full and not empty): count unchanged, both pointers advance
//  - Push into empty with no pop: the head becomes the new byte on the next cycle.
//  - level outputs equal the registered count and change the cycle after the transfer.
//  - The RX and TX paths are fully independent; no ordering between directions.
// CONFIGURATION
//  - USB_FIFO_FLUSH_EN defined:
//    - flush_rx/flush_tx ports exist.
//    - A flush high on an edge sets that FIFO's pointers and count to 0 and drops valid on the next cycle.
//    - flush takes priority over a push or pop in the same cycle; the pushed byte is discarded.
//  - USB_FIFO_FLUSH_EN undefined: the flush ports are absent and the FIFOs empty only on reset.
// STRUCTURE
//  - Package usb_serial_pkg holds:
//    - USB_BYTE_W = 8
//    - USB_FIFO_DEPTH_LOG2_DEF = 6
//    - typedef logic [USB_BYTE_W-1:0] usb_byte_t
//  - Sub-module usb_sync_fifo (DATA_W, DEPTH_LOG2; optional flush input) is instantiated twice, once for RX and once for TX.
//  - The top level is wiring only.
//  - Memory is inferred as a distributed RAM array, with no output reset on the array itself.
// TESTING
//  - Reset, then push 0x41 on usb_rx (rx_ready=0):
//    -> rx_valid=1 and rx_data=0x41 one cycle later; rx_level=1.
//  - Push 64 bytes 0x00..0x3F into TX with usb_tx_ready=0:
//    -> tx_ready=0 after the 64th byte, tx_level=64.
//    -> A 65th tx_valid is ignored.
//  - From full TX, hold usb_tx_ready=1 and tx_valid=1 together:
//    -> the first cycle pops only; tx_ready reasserts the next cycle.
//    -> The output order is 0x00..0x3F with no loss.
//  - Streaming push and pop every cycle for 200 bytes with a pseudo-random pattern:
//    -> rx_level stays constant; output equals input; pointers wrap correctly past 63.
//  - Assert rst_n low while the RX FIFO holds 10 bytes:
//    -> rx_valid=0 and rx_level=0 immediately; usb_rx_ready=1 after release.
//  - With USB_FIFO_FLUSH_EN: 5 bytes in RX, then flush_rx=1 together with a push of 0x55:
//    -> rx_valid=0 and rx_level=0 the next cycle; 0x55 is never output.

Source files
------------

// File: rtl/usb_serial_pkg.sv
// usb_serial_pkg: shared widths, default FIFO depth and byte type for the USB serial bridge
package usb_serial_pkg;
  localparam int USB_BYTE_W = 8;
  localparam int USB_FIFO_DEPTH_LOG2_DEF = 6;
  typedef logic [USB_BYTE_W-1:0] usb_byte_t;
endpackage

// File: rtl/usb_sync_fifo.sv
// usb_sync_fifo: FWFT synchronous FIFO with registered head; optional flush when USB_FIFO_FLUSH_EN is defined
module usb_sync_fifo
  import usb_serial_pkg::*;
#(
  parameter int DATA_W = USB_BYTE_W,
  parameter int DEPTH_LOG2 = USB_FIFO_DEPTH_LOG2_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef USB_FIFO_FLUSH_EN
  input  logic              flush,
`endif
  input  logic [DATA_W-1:0] wdata,
  input  logic              wvalid,
  output logic              wready,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  input  logic              rready,
  output logic [DEPTH_LOG2:0] level
);
  localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] ONE_CNT = {{DEPTH_LOG2{1'b0}}, 1'b1};
  logic [DATA_W-1:0] mem [1<<DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] wptr, rptr, rptr_n;
  logic [DEPTH_LOG2:0] count, count_n;
  logic push, pop, head_bypass;
`ifndef USB_FIFO_FLUSH_EN
  logic flush;
  assign flush = 1'b0;
`endif
  assign wready = count != FULL_CNT;
  assign rvalid = count != '0;
  assign level = count;
  assign push = wvalid && wready;
  assign pop = rvalid && rready;
  assign rptr_n = rptr + DEPTH_LOG2'(pop);
  assign count_n = count + (DEPTH_LOG2+1)'(push) - (DEPTH_LOG2+1)'(pop);
  assign head_bypass = push && count_n == ONE_CNT;
  // storage array, no reset so it maps onto distributed RAM
  always_ff @(posedge clk)
    if (push && !flush) mem[wptr] <= wdata;
  // pointers, count and registered head; the head takes the incoming byte when it becomes the only entry
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
      rdata <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      wptr <= wptr + DEPTH_LOG2'(push);
      rptr <= rptr_n;
      count <= count_n;
      if (count_n != '0) rdata <= head_bypass ? wdata : mem[rptr_n];
    end
endmodule

// File: rtl/usb_serial_fifo_bridge.sv
// usb_serial_fifo_bridge: RX/TX byte FIFOs between the USB controller and the serial register block; flush ports via USB_FIFO_FLUSH_EN
module usb_serial_fifo_bridge
  import usb_serial_pkg::*;
#(
  parameter int DATA_W = USB_BYTE_W,
  parameter int DEPTH_LOG2 = USB_FIFO_DEPTH_LOG2_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef USB_FIFO_FLUSH_EN
  input  logic              flush_rx,
  input  logic              flush_tx,
`endif
  input  logic [DATA_W-1:0] usb_rx_data,
  input  logic              usb_rx_valid,
  output logic              usb_rx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] usb_tx_data,
  output logic              usb_tx_valid,
  input  logic              usb_tx_ready,
  output logic [DEPTH_LOG2:0] rx_level,
  output logic [DEPTH_LOG2:0] tx_level
);
  usb_sync_fifo #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
    .clk(clk),
    .rst_n(rst_n),
`ifdef USB_FIFO_FLUSH_EN
    .flush(flush_rx),
`endif
    .wdata(usb_rx_data),
    .wvalid(usb_rx_valid),
    .wready(usb_rx_ready),
    .rdata(rx_data),
    .rvalid(rx_valid),
    .rready(rx_ready),
    .level(rx_level)
  );
  usb_sync_fifo #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
    .clk(clk),
    .rst_n(rst_n),
`ifdef USB_FIFO_FLUSH_EN
    .flush(flush_tx),
`endif
    .wdata(tx_data),
    .wvalid(tx_valid),
    .wready(tx_ready),
    .rdata(usb_tx_data),
    .rvalid(usb_tx_valid),
    .rready(usb_tx_ready),
    .level(tx_level)
  );
endmodule

// File: tb/tb_usb_serial_fifo_bridge.sv
// tb_usb_serial_fifo_bridge: directed self-checking bench for the USB serial FIFO bridge
module tb_usb_serial_fifo_bridge;
  logic clk = 1'b0;
  logic rst_n;
`ifdef USB_FIFO_FLUSH_EN
  logic flush_rx, flush_tx;
`endif
  logic [7:0] usb_rx_data, rx_data, tx_data, usb_tx_data;
  logic usb_rx_valid, usb_rx_ready, rx_valid, rx_ready;
  logic tx_valid, tx_ready, usb_tx_valid, usb_tx_ready;
  logic [6:0] rx_level, tx_level;
  int errs = 0;
  int n_chk = 0;
  logic [7:0] q [$];
  usb_serial_fifo_bridge dut (
    .clk(clk),
    .rst_n(rst_n),
`ifdef USB_FIFO_FLUSH_EN
    .flush_rx(flush_rx),
    .flush_tx(flush_tx),
`endif
    .usb_rx_data(usb_rx_data),
    .usb_rx_valid(usb_rx_valid),
    .usb_rx_ready(usb_rx_ready),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .usb_tx_data(usb_tx_data),
    .usb_tx_valid(usb_tx_valid),
    .usb_tx_ready(usb_tx_ready),
    .rx_level(rx_level),
    .tx_level(tx_level)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [7:0] pat(input int i);
    return 8'((i * 37 + 11) ^ (i >> 3));
  endfunction
  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    rst_n = 1'b0;
`ifdef USB_FIFO_FLUSH_EN
    flush_rx = 1'b0;
    flush_tx = 1'b0;
`endif
    usb_rx_data = '0; usb_rx_valid = 1'b0; rx_ready = 1'b0;
    tx_data = '0; tx_valid = 1'b0; usb_tx_ready = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check("rst_usb_rx_ready", usb_rx_ready, 1);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_usb_tx_valid", usb_tx_valid, 0);
    check("rst_usb_tx_data", usb_tx_data, 0);
    check("rst_rx_level", rx_level, 0);
    check("rst_tx_level", tx_level, 0);
    // single byte into RX
    usb_rx_data = 8'h41; usb_rx_valid = 1'b1;
    tick();
    usb_rx_valid = 1'b0;
    check("rx1_valid", rx_valid, 1);
    check("rx1_data", rx_data, 8'h41);
    check("rx1_level", rx_level, 1);
    tick();
    check("rx1_hold", rx_data, 8'h41);
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    check("rx1_pop_valid", rx_valid, 0);
    check("rx1_pop_level", rx_level, 0);
    // fill TX to full
    tx_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      tx_data = 8'(i);
      tick();
    end
    check("txfull_ready", tx_ready, 0);
    check("txfull_level", tx_level, 64);
    check("txfull_head", usb_tx_data, 8'h00);
    tx_data = 8'hEE;
    tick();
    check("tx65_level", tx_level, 64);
    check("tx65_ready", tx_ready, 0);
    // pop from full with a simultaneous push attempt
    tx_data = 8'hA0; usb_tx_ready = 1'b1;
    tick();
    tx_valid = 1'b0;
    check("txpop_ready", tx_ready, 1);
    check("txpop_level", tx_level, 63);
    for (int i = 1; i < 64; i++) begin
      check("txdrain_data", usb_tx_data, 32'(i));
      tick();
    end
    usb_tx_ready = 1'b0;
    check("txdrain_valid", usb_tx_valid, 0);
    check("txdrain_level", tx_level, 0);
    // streaming RX with 5 bytes resident
    usb_rx_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      usb_rx_data = pat(i);
      q.push_back(pat(i));
      tick();
    end
    rx_ready = 1'b1;
    for (int i = 5; i < 205; i++) begin
      usb_rx_data = pat(i);
      check("stream_data", rx_data, q[0]);
      tick();
      void'(q.pop_front());
      q.push_back(pat(i));
      check("stream_level", rx_level, 5);
    end
    usb_rx_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("stream_tail", rx_data, q[0]);
      tick();
      void'(q.pop_front());
    end
    rx_ready = 1'b0;
    check("stream_empty", rx_valid, 0);
    // reset with 10 bytes buffered
    usb_rx_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      usb_rx_data = 8'(i + 8'h20);
      tick();
    end
    usb_rx_valid = 1'b0;
    check("pre_rst_level", rx_level, 10);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", rx_valid, 0);
    check("mid_rst_level", rx_level, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_ready", usb_rx_ready, 1);
    check("post_rst_valid", rx_valid, 0);
`ifdef USB_FIFO_FLUSH_EN
    usb_rx_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      usb_rx_data = 8'(i + 1);
      tick();
    end
    usb_rx_data = 8'h55; flush_rx = 1'b1;
    tick();
    flush_rx = 1'b0; usb_rx_valid = 1'b0;
    check("flush_valid", rx_valid, 0);
    check("flush_level", rx_level, 0);
    usb_rx_data = 8'h12; usb_rx_valid = 1'b1;
    tick();
    usb_rx_valid = 1'b0;
    check("post_flush_head", rx_data, 8'h12);
    check("post_flush_level", rx_level, 1);
`endif
    $display("Result: errors=%0d of %0d checks", errs, n_chk);
    $finish;
  end
endmodule
